// File: rtl/axis_core_bridge.sv
// Length-prefixed AXI-Stream to compute-core bridge with a result FIFO.
// Optional length/TLAST checking: define AXIS_BRIDGE_LEN_CHECK_EN.
module axis_core_bridge #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [DATA_W-1:0]   S_AXIS_TDATA,
    input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
    input  logic                S_AXIS_TLAST,
    input  logic                S_AXIS_TVALID,
    output logic                S_AXIS_TREADY,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
    output logic                M_AXIS_TLAST,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [DATA_W-1:0]   core_in_data,
    output logic                core_in_valid,
    input  logic                core_in_ready,
    input  logic [DATA_W-1:0]   core_out_data,
    input  logic                core_out_valid,
    input  logic                core_out_last,
    output logic                core_out_ready,
    output logic                busy,
    output logic                err
);

    localparam int KW = DATA_W / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        ST_HDR = 1'b0,
        ST_PAY = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    rem_q;
    logic [PW-1:0]       wptr_q;
    logic [PW-1:0]       rptr_q;
    logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];
    logic [KW-1:0]       keep_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                s_ready;
    logic                cin_valid;
    logic                s_xfer;
    logic [CNT_W-1:0]    hdr_cnt;
    logic                hdr_zero;
    logic                rem_one;
    logic                core_push;
    logic                null_push;
    logic                push;
    logic                pop;
    logic                m_valid;
    logic [DATA_W-1:0]   push_data;
    logic [KW-1:0]       push_keep;
    logic                push_last;
    logic                unused_ok;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign hdr_cnt  = S_AXIS_TDATA[CNT_W-1:0];
    assign hdr_zero = (hdr_cnt == '0);
    assign rem_one  = (rem_q == CNT_W'(1));

    // Input-side handshake: header gated by FIFO space, payload by the core
    always_comb begin
        s_ready   = 1'b0;
        cin_valid = 1'b0;
        if (!ARESET) begin
            case (state_q)
                ST_HDR: s_ready = !fifo_full && !core_out_valid;
                ST_PAY: begin
                    s_ready   = core_in_ready;
                    cin_valid = S_AXIS_TVALID;
                end
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign s_xfer = S_AXIS_TVALID && s_ready;

    // Core results take priority; a zero header only pushes when the core is idle
    assign core_push = core_out_valid && core_out_ready;
    assign null_push = (state_q == ST_HDR) && s_xfer && hdr_zero;
    assign push      = core_push || null_push;
    assign m_valid   = !ARESET && !fifo_empty;
    assign pop       = m_valid && M_AXIS_TREADY;

    assign push_data = core_push ? core_out_data : '0;
    assign push_keep = core_push ? {KW{1'b1}} : '0;
    assign push_last = core_push ? core_out_last : 1'b1;

    // Input FSM: header loads the count, payload words count it down
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_HDR;
            rem_q   <= '0;
        end else if (s_xfer) begin
            case (state_q)
                ST_HDR: begin
                    rem_q <= hdr_cnt;
                    if (!hdr_zero) begin
                        state_q <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_one) begin
                        state_q <= ST_HDR;
                    end
`ifdef AXIS_BRIDGE_LEN_CHECK_EN
                    if (S_AXIS_TLAST) begin
                        state_q <= ST_HDR;
                    end
`endif
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    // FIFO storage, written at the tail on every accepted push
    always_ff @(posedge ACLK) begin
        if (push) begin
            data_mem_q[wptr_q[AW-1:0]] <= push_data;
            keep_mem_q[wptr_q[AW-1:0]] <= push_keep;
            last_mem_q[wptr_q[AW-1:0]] <= push_last;
        end
    end

    // FIFO pointers, one extra wrap bit for full/empty detection
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
        end
    end

`ifdef AXIS_BRIDGE_LEN_CHECK_EN
    logic err_q;
    logic len_err;

    assign len_err = s_xfer &&
        (((state_q == ST_HDR) && !hdr_zero && S_AXIS_TLAST) ||
         ((state_q == ST_PAY) && (S_AXIS_TLAST != rem_one)));

    // Sticky framing error, cleared only by reset
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_q <= 1'b0;
        end else if (len_err) begin
            err_q <= 1'b1;
        end
    end

    assign err       = err_q;
    assign unused_ok = ^S_AXIS_TKEEP;
`else
    assign err       = 1'b0;
    assign unused_ok = ^{S_AXIS_TKEEP, S_AXIS_TLAST};
`endif

    assign S_AXIS_TREADY  = s_ready;
    assign core_in_data   = S_AXIS_TDATA;
    assign core_in_valid  = cin_valid;
    assign core_out_ready = !ARESET && !fifo_full;
    assign M_AXIS_TVALID  = m_valid;
    assign M_AXIS_TDATA   = m_valid ? data_mem_q[rptr_q[AW-1:0]] : '0;
    assign M_AXIS_TKEEP   = m_valid ? keep_mem_q[rptr_q[AW-1:0]] : '0;
    assign M_AXIS_TLAST   = m_valid && last_mem_q[rptr_q[AW-1:0]];
    assign busy           = !ARESET && ((state_q == ST_PAY) || !fifo_empty);

endmodule

// File: tb/tb_axis_core_bridge.sv
// Randomised bench for axis_core_bridge against a queue-based model.
// Framing-check cases run only when AXIS_BRIDGE_LEN_CHECK_EN is defined.
module tb_axis_core_bridge;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
    } ent_t;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } sb_t;

    logic          ACLK = 0;
    logic          ARESET;
    logic [DW-1:0] S_AXIS_TDATA;
    logic [1:0]    S_AXIS_TKEEP;
    logic          S_AXIS_TLAST;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic [1:0]    M_AXIS_TKEEP;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic [DW-1:0] core_in_data;
    logic          core_in_valid;
    logic          core_in_ready;
    logic [DW-1:0] core_out_data;
    logic          core_out_valid;
    logic          core_out_last;
    logic          core_out_ready;
    logic          busy;
    logic          err;

    axis_core_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid),
        .core_in_ready(core_in_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid),
        .core_out_last(core_out_last), .core_out_ready(core_out_ready),
        .busy(busy), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    bit   m_pay;
    int   m_rem;
    bit   m_err;
    ent_t m_fifo[$];
    ent_t m_seen[$];
    ent_t exp_out[$];
    logic [15:0] core_seen[$];
    logic [15:0] exp_core[$];

    // stimulus state
    sb_t s_beats[$];
    sb_t core_q[$];
    int  m_mode;
    int  cir_mode;
    bit  s_rand;
    bit  c_rand;

    // per-cycle handshake flags from the model
    bit          s_x, cin_x, cin_last, cout_x, m_x;
    logic [15:0] cin_d;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // per-cycle compare and model update
    always @(negedge ACLK) begin
        bit full, empty, e_sr, e_civ;
        if (ARESET) begin
            chk("rst s_tready", S_AXIS_TREADY, 0);
            chk("rst core_in_valid", core_in_valid, 0);
            chk("rst core_out_ready", core_out_ready, 0);
            chk("rst m_tvalid", M_AXIS_TVALID, 0);
            chk("rst m_tlast", M_AXIS_TLAST, 0);
            chk("rst m_tkeep", M_AXIS_TKEEP, 0);
            chk("rst busy", busy, 0);
            chk("rst err", err, 0);
            m_pay = 0; m_rem = 0; m_err = 0;
            m_fifo.delete();
            s_x = 0; cin_x = 0; cout_x = 0; m_x = 0; cin_last = 0;
        end else begin
            full  = (m_fifo.size() == DEPTH);
            empty = (m_fifo.size() == 0);
            e_sr  = m_pay ? core_in_ready : (!full && !core_out_valid);
            e_civ = m_pay && S_AXIS_TVALID;
            chk("s_tready", S_AXIS_TREADY, e_sr);
            chk("core_in_valid", core_in_valid, e_civ);
            if (e_civ) chk("core_in_data", core_in_data, S_AXIS_TDATA);
            chk("core_out_ready", core_out_ready, !full);
            chk("m_tvalid", M_AXIS_TVALID, !empty);
            if (!empty) begin
                chk("m_tdata", M_AXIS_TDATA, m_fifo[0].d);
                chk("m_tkeep", M_AXIS_TKEEP, m_fifo[0].k);
                chk("m_tlast", M_AXIS_TLAST, m_fifo[0].l);
            end
            chk("busy", busy, m_pay || !empty);
            chk("err", err, m_err);

            s_x      = S_AXIS_TVALID && e_sr;
            cin_x    = m_pay && s_x;
            cin_d    = S_AXIS_TDATA;
            cin_last = (m_rem == 1);
            cout_x   = core_out_valid && !full;
            m_x      = !empty && M_AXIS_TREADY;

            if (m_x) m_seen.push_back(m_fifo.pop_front());
            if (cout_x)
                m_fifo.push_back('{d: core_out_data, k: 2'b11, l: core_out_last});
            else if (!m_pay && s_x && S_AXIS_TDATA == 0)
                m_fifo.push_back('{d: 16'd0, k: 2'b00, l: 1'b1});

            if (s_x && !m_pay) begin
                m_rem = int'(S_AXIS_TDATA);
                if (m_rem != 0) m_pay = 1;
`ifdef AXIS_BRIDGE_LEN_CHECK_EN
                if (m_rem != 0 && S_AXIS_TLAST) m_err = 1;
`endif
            end else if (s_x) begin
                core_seen.push_back(S_AXIS_TDATA);
`ifdef AXIS_BRIDGE_LEN_CHECK_EN
                if (S_AXIS_TLAST != (m_rem == 1)) m_err = 1;
                if (S_AXIS_TLAST) m_pay = 0;
`endif
                m_rem = m_rem - 1;
                if (m_rem == 0) m_pay = 0;
            end
        end
    end

    // stimulus drivers: DMA source, echoing core (+1), DMA sink
    always @(posedge ACLK) begin
        #1;
        if (!ARESET) begin
            if (s_x) void'(s_beats.pop_front());
            if (cout_x) void'(core_q.pop_front());
            if (cin_x) core_q.push_back('{d: cin_d + 16'd1, l: cin_last});
            if (!S_AXIS_TVALID || s_x) begin
                if (s_beats.size() > 0 && (!s_rand || $urandom_range(0, 3) != 0)) begin
                    S_AXIS_TVALID = 1;
                    S_AXIS_TDATA  = s_beats[0].d;
                    S_AXIS_TLAST  = s_beats[0].l;
                end else begin
                    S_AXIS_TVALID = 0;
                end
            end
            if (!core_out_valid || cout_x) begin
                if (core_q.size() > 0 && (!c_rand || $urandom_range(0, 2) != 0)) begin
                    core_out_valid = 1;
                    core_out_data  = core_q[0].d;
                    core_out_last  = core_q[0].l;
                end else begin
                    core_out_valid = 0;
                end
            end
            case (m_mode)
                0: M_AXIS_TREADY = 0;
                1: M_AXIS_TREADY = 1;
                default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
            case (cir_mode)
                0: core_in_ready = 1;
                1: core_in_ready = !core_in_ready;
                default: core_in_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_pkt(input int len, input bit rnd, input int base);
        logic [15:0] w;
        s_beats.push_back('{d: 16'(len), l: (len == 0)});
        if (len == 0) exp_out.push_back('{d: 16'd0, k: 2'b00, l: 1'b1});
        for (int i = 0; i < len; i++) begin
            w = rnd ? 16'($urandom) : 16'(base * (i + 1));
            s_beats.push_back('{d: w, l: (i == len - 1)});
            exp_core.push_back(w);
            exp_out.push_back('{d: w + 16'd1, k: 2'b11, l: (i == len - 1)});
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (n < limit && !(s_beats.size() == 0 && core_q.size() == 0 &&
               !S_AXIS_TVALID && !core_out_valid && m_fifo.size() == 0 && !m_pay)) begin
            @(posedge ACLK);
            n++;
        end
        chk("idle timeout", n < limit, 1);
        repeat (2) @(posedge ACLK);
    endtask

    task automatic check_streams(input string tag);
        chk({tag, " out count"}, m_seen.size(), exp_out.size());
        for (int i = 0; i < m_seen.size() && i < exp_out.size(); i++)
            chk({tag, " out beat"}, m_seen[i], exp_out[i]);
        chk({tag, " core count"}, core_seen.size(), exp_core.size());
        for (int i = 0; i < core_seen.size() && i < exp_core.size(); i++)
            chk({tag, " core word"}, core_seen[i], exp_core[i]);
        m_seen.delete(); exp_out.delete();
        core_seen.delete(); exp_core.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1;
        S_AXIS_TDATA = 0; S_AXIS_TKEEP = '1; S_AXIS_TLAST = 0; S_AXIS_TVALID = 0;
        M_AXIS_TREADY = 1; core_in_ready = 1;
        core_out_data = 0; core_out_valid = 0; core_out_last = 0;
        m_mode = 1; cir_mode = 0; s_rand = 0; c_rand = 0;
        repeat (3) @(posedge ACLK);
        #3 ARESET = 0;
        @(negedge ACLK);
        chk("post-rst s_tready", S_AXIS_TREADY, 1);
        chk("post-rst m_tvalid", M_AXIS_TVALID, 0);
        chk("post-rst busy", busy, 0);

        // basic packet
        send_pkt(3, 0, 10);
        wait_idle(200);
        chk("t1 core0", core_seen[0], 16'd10);
        chk("t1 core1", core_seen[1], 16'd20);
        chk("t1 core2", core_seen[2], 16'd30);
        chk("t1 out0", m_seen[0], {16'd11, 2'b11, 1'b0});
        chk("t1 out1", m_seen[1], {16'd21, 2'b11, 1'b0});
        chk("t1 out2", m_seen[2], {16'd31, 2'b11, 1'b1});
        check_streams("t1");

        // zero-length packet followed immediately by another header
        send_pkt(0, 0, 0);
        send_pkt(1, 0, 5);
        wait_idle(200);
        chk("t2 null", m_seen[0], {16'd0, 2'b00, 1'b1});
        chk("t2 next", m_seen[1], {16'd6, 2'b11, 1'b1});
        check_streams("t2");

        // FIFO full with sink stalled
        m_mode = 0;
        send_pkt(6, 0, 1);
        repeat (30) @(posedge ACLK);
        @(negedge ACLK);
        chk("t3 core_out_ready", core_out_ready, 0);
        chk("t3 m_tvalid", M_AXIS_TVALID, 1);
        chk("t3 fifo level", m_fifo.size(), 4);
        chk("t3 core pending", core_q.size(), 2);
        m_mode = 1;
        wait_idle(200);
        chk("t3 last beat", m_seen[5], {16'd7, 2'b11, 1'b1});
        check_streams("t3");

        // core_in_ready toggling during a 5-word payload
        cir_mode = 1;
        send_pkt(5, 0, 7);
        wait_idle(200);
        chk("t4 core xfers", core_seen.size(), 5);
        check_streams("t4");
        cir_mode = 0;

        // asynchronous reset mid-payload with two results buffered
        m_mode = 0;
        s_beats.push_back('{d: 16'd4, l: 1'b0});
        s_beats.push_back('{d: 16'd40, l: 1'b0});
        s_beats.push_back('{d: 16'd41, l: 1'b0});
        repeat (12) @(posedge ACLK);
        @(negedge ACLK);
        chk("t5 buffered", m_fifo.size(), 2);
        chk("t5 in payload", busy, 1);
        @(posedge ACLK);
        #3 ARESET = 1;
        #1;
        chk("t5 s_tready", S_AXIS_TREADY, 0);
        chk("t5 core_in_valid", core_in_valid, 0);
        chk("t5 core_out_ready", core_out_ready, 0);
        chk("t5 m_tvalid", M_AXIS_TVALID, 0);
        chk("t5 m_tlast", M_AXIS_TLAST, 0);
        chk("t5 busy", busy, 0);
        s_beats.delete(); core_q.delete();
        S_AXIS_TVALID = 0; core_out_valid = 0; m_mode = 1;
        repeat (2) @(posedge ACLK);
        #3 ARESET = 0;
        m_seen.delete(); core_seen.delete();
        @(negedge ACLK);
        chk("t5 hdr ready", S_AXIS_TREADY, 1);
        chk("t5 m_tvalid after", M_AXIS_TVALID, 0);
        chk("t5 busy after", busy, 0);

`ifdef AXIS_BRIDGE_LEN_CHECK_EN
        // early TLAST on a 4-word packet
        s_beats.push_back('{d: 16'd4, l: 1'b0});
        s_beats.push_back('{d: 16'd100, l: 1'b0});
        s_beats.push_back('{d: 16'd200, l: 1'b1});
        wait_idle(200);
        chk("t6 err", err, 1);
        chk("t6 busy", busy, 0);
        chk("t6 out0", m_seen[0], {16'd101, 2'b11, 1'b0});
        chk("t6 out1", m_seen[1], {16'd201, 2'b11, 1'b0});
        m_seen.delete(); core_seen.delete();
        send_pkt(2, 0, 50);
        wait_idle(200);
        check_streams("t6");
        chk("t6 err sticky", err, 1);
        ARESET = 1;
        @(posedge ACLK);
        #3 ARESET = 0;
        @(negedge ACLK);
`endif

        // randomised traffic with random backpressure everywhere
        s_rand = 1; c_rand = 1; m_mode = 2; cir_mode = 2;
        for (int p = 0; p < 40; p++) send_pkt($urandom_range(0, 5), 1, 0);
        wait_idle(5000);
        check_streams("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
